// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU sequencer: opcodes, FSM state,
// operation classes and the per-nibble ALU select mapping.
package alu_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_ADC  = 4'b0010;
    localparam logic [3:0] OP_SBC  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_NAND = 4'b1000;
    localparam logic [3:0] OP_XNOR = 4'b1001;
    localparam logic [3:0] OP_LT   = 4'b1010;
    localparam logic [3:0] OP_GT   = 4'b1011;
    localparam logic [3:0] OP_EQ   = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        CLS_ADD   = 2'd0,
        CLS_SUB   = 2'd1,
        CLS_LOGIC = 2'd2,
        CLS_CMP   = 2'd3
    } op_class_e;

    // Unused opcodes 1101-1111 fall into the add class, like the ALU default.
    function automatic op_class_e op_class(input logic [3:0] op);
        case (op)
            OP_SUB, OP_SBC:                                     op_class = CLS_SUB;
            OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR:    op_class = CLS_LOGIC;
            OP_LT, OP_GT, OP_EQ:                                op_class = CLS_CMP;
            default:                                            op_class = CLS_ADD;
        endcase
    endfunction

    function automatic logic [3:0] nibble_sel(input logic [3:0] op, input logic first);
        case (op)
            OP_SUB, OP_LT, OP_GT, OP_EQ:                        nibble_sel = first ? OP_SUB : OP_SBC;
            OP_SBC:                                             nibble_sel = OP_SBC;
            OP_ADC:                                             nibble_sel = OP_ADC;
            OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NAND, OP_XNOR:    nibble_sel = op;
            default:                                            nibble_sel = first ? OP_ADD : OP_ADC;
        endcase
    endfunction

endpackage

// File: rtl/nibble_shreg.sv
// Wide register addressed in 4-bit nibbles: whole-word load, one nibble
// written by index per cycle, and one nibble presented by index.
module nibble_shreg
    import alu_pkg::*;
#(
    parameter int NIBBLES = 4,
    parameter int IDX_W   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [NIBBLE_W*NIBBLES-1:0]   load_data,
    input  logic                          wr_en,
    input  logic [IDX_W-1:0]              wr_idx,
    input  logic [NIBBLE_W-1:0]           wr_nib,
    input  logic [IDX_W-1:0]              rd_idx,
    output logic [NIBBLE_W-1:0]           rd_nib,
    output logic [NIBBLE_W*NIBBLES-1:0]   data
);

    logic [NIBBLE_W*NIBBLES-1:0] data_r;
    logic [NIBBLE_W-1:0]         rd_nib_s;

    // Storage: word load has priority over the indexed nibble write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= '0;
        end else if (load) begin
            data_r <= load_data;
        end else if (wr_en) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    data_r[i*NIBBLE_W +: NIBBLE_W] <= wr_nib;
                end
            end
        end
    end

    // Read mux; an out-of-range index reads as zero
    always_comb begin
        rd_nib_s = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            rd_nib_s = (rd_idx == IDX_W'(i)) ? data_r[i*NIBBLE_W +: NIBBLE_W] : rd_nib_s;
        end
    end

    assign rd_nib = rd_nib_s;
    assign data   = data_r;

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Drives a 4-bit ALU one nibble per cycle (LSB first) to execute one wide op.
// Optional macro ALU_SEQ_OVF_EN adds the rsp_ovf signed-overflow output.
module alu_nibble_sequencer
    import alu_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [3:0]                  req_op,
    input  logic [NIBBLE_W*NIBBLES-1:0] req_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] req_b,
    input  logic                        req_cin,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] rsp_result,
    output logic                        rsp_carry,
    output logic                        rsp_zero,
`ifdef ALU_SEQ_OVF_EN
    output logic                        rsp_ovf,
`endif
    output logic [3:0]                  alu_a,
    output logic [3:0]                  alu_b,
    output logic [3:0]                  alu_sel,
    output logic                        alu_cin,
    input  logic [3:0]                  alu_result,
    input  logic                        alu_cout
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

    seq_state_e       state_r;
    logic [3:0]       op_r;
    logic [IDX_W-1:0] cnt_r;
    logic             allzero_r;
    logic [W-1:0]     b_sh_r;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic [W-1:0]     rsp_result_r;
    logic             rsp_carry_r;
    logic             rsp_zero_r;
    logic [3:0]       alu_a_r;
    logic [3:0]       alu_b_r;
    logic [3:0]       alu_sel_r;
    logic             alu_cin_r;

    logic             accept_s;
    logic             exec_s;
    logic [3:0]       a_nib_s;
    logic [W-1:0]     res_data_s;
    op_class_e        cls_s;
    logic             eq_s;
    logic [W-1:0]     final_s;
    logic             carry_s;
`ifdef ALU_SEQ_OVF_EN
    logic             rsp_ovf_r;
    logic             ovf_s;
`endif

    assign accept_s = (state_r == ST_IDLE) && req_valid;
    assign exec_s   = (state_r == ST_EXEC);

    // Operand A is overwritten in place by the result; nibble i+1 is still A when read
    nibble_shreg #(
        .NIBBLES (NIBBLES),
        .IDX_W   (IDX_W)
    ) u_res (
        .clk       (clk),
        .rst       (rst),
        .load      (accept_s),
        .load_data (req_a),
        .wr_en     (exec_s),
        .wr_idx    (cnt_r),
        .wr_nib    (alu_result),
        .rd_idx    (cnt_r + 1'b1),
        .rd_nib    (a_nib_s),
        .data      (res_data_s)
    );

    // Final response value, taken combinationally at the last EXEC edge
    always_comb begin
        cls_s   = op_class(op_r);
        eq_s    = allzero_r & (alu_result == 4'h0);
        final_s = {alu_result, res_data_s[W-NIBBLE_W-1:0]};
        carry_s = alu_cout;
        case (cls_s)
            CLS_CMP: begin
                case (op_r)
                    OP_LT:   final_s = W'(alu_cout);
                    OP_EQ:   final_s = W'(eq_s);
                    default: final_s = W'(!alu_cout && !eq_s);
                endcase
            end
            CLS_LOGIC: begin
                carry_s = 1'b0;
            end
            default: begin
                carry_s = alu_cout;
            end
        endcase
`ifdef ALU_SEQ_OVF_EN
        ovf_s = 1'b0;
        if (cls_s == CLS_ADD || cls_s == CLS_SUB) begin
            ovf_s = (alu_a_r[3] == (alu_b_r[3] ^ (cls_s == CLS_SUB))) && (alu_result[3] != alu_a_r[3]);
        end else begin
            ovf_s = 1'b0;
        end
`endif
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            op_r         <= OP_ADD;
            cnt_r        <= '0;
            allzero_r    <= 1'b0;
            b_sh_r       <= '0;
            req_ready_r  <= 1'b1;
            rsp_valid_r  <= 1'b0;
            rsp_result_r <= '0;
            rsp_carry_r  <= 1'b0;
            rsp_zero_r   <= 1'b0;
            alu_a_r      <= 4'h0;
            alu_b_r      <= 4'h0;
            alu_sel_r    <= 4'b0000;
            alu_cin_r    <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            rsp_ovf_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_r     <= ST_EXEC;
                        req_ready_r <= 1'b0;
                        op_r        <= req_op;
                        cnt_r       <= '0;
                        allzero_r   <= 1'b1;
                        alu_a_r     <= req_a[3:0];
                        alu_b_r     <= req_b[3:0];
                        b_sh_r      <= req_b >> NIBBLE_W;
                        alu_sel_r   <= nibble_sel(req_op, 1'b1);
                        alu_cin_r   <= (req_op == OP_ADC || req_op == OP_SBC) ? req_cin : 1'b0;
                    end
                end
                ST_EXEC: begin
                    allzero_r <= allzero_r & (alu_result == 4'h0);
                    if (cnt_r == LAST) begin
                        state_r      <= ST_RESP;
                        rsp_valid_r  <= 1'b1;
                        rsp_result_r <= final_s;
                        rsp_carry_r  <= carry_s;
                        rsp_zero_r   <= (final_s == '0);
                        alu_a_r      <= 4'h0;
                        alu_b_r      <= 4'h0;
                        alu_sel_r    <= 4'b0000;
                        alu_cin_r    <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
                        rsp_ovf_r    <= ovf_s;
`endif
                    end else begin
                        cnt_r     <= cnt_r + 1'b1;
                        alu_a_r   <= a_nib_s;
                        alu_b_r   <= b_sh_r[3:0];
                        b_sh_r    <= b_sh_r >> NIBBLE_W;
                        alu_sel_r <= nibble_sel(op_r, 1'b0);
                        alu_cin_r <= (cls_s == CLS_LOGIC) ? 1'b0 : alu_cout;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_r     <= ST_IDLE;
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    req_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = rsp_result_r;
    assign rsp_carry  = rsp_carry_r;
    assign rsp_zero   = rsp_zero_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_sel    = alu_sel_r;
    assign alu_cin    = alu_cin_r;
`ifdef ALU_SEQ_OVF_EN
    assign rsp_ovf    = rsp_ovf_r;
`endif

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_nibble_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        req_cin;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_zero;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_sel;
    logic        alu_cin;
    logic [3:0]  alu_result;
    logic        alu_cout;
`ifdef ALU_SEQ_OVF_EN
    logic        rsp_ovf;
`endif

    int          n_total = 0;
    int          n_pass  = 0;
    logic [3:0]  sel_log [4];
    logic        cin_log [4];
    int          seen_valid;

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.NIBBLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero),
`ifdef ALU_SEQ_OVF_EN
        .rsp_ovf    (rsp_ovf),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    // Behavioural 4-bit ALU
    always_comb begin
        logic [4:0] t;
        t = 5'd0;
        case (alu_sel)
            4'b0000: t = {1'b0, alu_a} + {1'b0, alu_b};
            4'b0001: t = {1'b0, alu_a} - {1'b0, alu_b};
            4'b0010: t = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0000, alu_cin};
            4'b0011: t = {1'b0, alu_a} - {1'b0, alu_b} - {4'b0000, alu_cin};
            4'b0100: t = {1'b0, alu_a & alu_b};
            4'b0101: t = {1'b0, alu_a | alu_b};
            4'b0110: t = {1'b0, alu_a ^ alu_b};
            4'b0111: t = {1'b0, ~(alu_a | alu_b)};
            4'b1000: t = {1'b0, ~(alu_a & alu_b)};
            4'b1001: t = {1'b0, ~(alu_a ^ alu_b)};
            default: t = {1'b0, alu_a} + {1'b0, alu_b};
        endcase
        alu_result = t[3:0];
        alu_cout   = t[4];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Issue a request, log alu_sel/alu_cin per EXEC cycle, end at the first RESP negedge
    task automatic start_req(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                             input logic cin);
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_op = 4'hF; req_a = 16'hDEAD; req_b = 16'h5A5A; req_cin = ~cin;
        check("req_ready_busy", req_ready, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            sel_log[k] = alu_sel;
            cin_log[k] = alu_cin;
        end
        check("rsp_valid_early", rsp_valid, 0);
        @(negedge clk);
        check("rsp_latency", rsp_valid, 1);
    endtask

    task automatic check_rsp(input string tag, input logic [15:0] res, input logic carry,
                             input logic zero);
        check({tag, "_result"}, rsp_result, res);
        check({tag, "_carry"}, rsp_carry, carry);
        check({tag, "_zero"}, rsp_zero, zero);
    endtask

    task automatic finish_rsp;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", rsp_valid, 0);
        check("req_ready_back", req_ready, 1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_a = 16'h0; req_b = 16'h0;
        req_cin = 1'b0; rsp_ready = 1'b0;
        #2;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_carry", rsp_carry, 0);
        check("rst_rsp_zero", rsp_zero, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_sel", alu_sel, 0);
        check("rst_alu_cin", alu_cin, 0);
`ifdef ALU_SEQ_OVF_EN
        check("rst_rsp_ovf", rsp_ovf, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // ADD with full carry ripple
        start_req(4'b0000, 16'hFFFF, 16'h0001, 1'b0);
        check_rsp("add", 16'h0000, 1'b1, 1'b1);
        check("add_sel0", sel_log[0], 4'b0000);
        check("add_sel1", sel_log[1], 4'b0010);
        check("add_sel2", sel_log[2], 4'b0010);
        check("add_sel3", sel_log[3], 4'b0010);
        check("add_cin0", cin_log[0], 0);
        check("add_cin3", cin_log[3], 1);
        finish_rsp();

        // SUB with borrow out
        start_req(4'b0001, 16'h1234, 16'h1235, 1'b0);
        check_rsp("sub", 16'hFFFF, 1'b1, 1'b0);
        check("sub_sel0", sel_log[0], 4'b0001);
        check("sub_sel1", sel_log[1], 4'b0011);
        finish_rsp();

        // Reset during the second EXEC cycle
        @(negedge clk);
        req_valid = 1'b1; req_op = 4'b0000; req_a = 16'h00FF; req_b = 16'h0001;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_alu_a", alu_a, 4'hF);
        rst = 1'b1;
        #1;
        check("mrst_req_ready", req_ready, 1);
        check("mrst_rsp_valid", rsp_valid, 0);
        check("mrst_rsp_result", rsp_result, 0);
        check("mrst_rsp_carry", rsp_carry, 0);
        check("mrst_alu_a", alu_a, 0);
        check("mrst_alu_sel", alu_sel, 0);
        check("mrst_alu_cin", alu_cin, 0);
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen_valid++;
        end
        check("mrst_no_rsp", seen_valid, 0);

        // ADC after reset: carry chained from the MSB
        start_req(4'b0010, 16'h8000, 16'h8000, 1'b1);
        check_rsp("adc", 16'h0001, 1'b1, 1'b0);
        finish_rsp();

        // SBC with borrow in
        start_req(4'b0011, 16'h0100, 16'h0000, 1'b1);
        check_rsp("sbc", 16'h00FF, 1'b0, 1'b0);
        check("sbc_sel0", sel_log[0], 4'b0011);
        check("sbc_cin0", cin_log[0], 1);
        finish_rsp();

        // XOR: select constant, alu_cin always 0
        start_req(4'b0110, 16'hA5A5, 16'hFFFF, 1'b1);
        check_rsp("xor", 16'h5A5A, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("xor_sel", sel_log[k], 4'b0110);
            check("xor_cin", cin_log[k], 0);
        end
        finish_rsp();

        start_req(4'b1010, 16'h00FF, 16'h0100, 1'b0);
        check_rsp("lt", 16'h0001, 1'b1, 1'b0);
        check("lt_sel1", sel_log[1], 4'b0011);
        finish_rsp();

        start_req(4'b1011, 16'h00FF, 16'h0100, 1'b0);
        check_rsp("gt", 16'h0000, 1'b1, 1'b1);
        finish_rsp();

        start_req(4'b1100, 16'hBEEF, 16'hBEEF, 1'b0);
        check_rsp("eq", 16'h0001, 1'b0, 1'b0);
        finish_rsp();

        start_req(4'b0100, 16'hFF00, 16'h0FF0, 1'b0);
        check_rsp("and", 16'h0F00, 1'b0, 1'b0);
        finish_rsp();

        start_req(4'b1000, 16'h0000, 16'h0000, 1'b0);
        check_rsp("nand", 16'hFFFF, 1'b0, 1'b0);
        finish_rsp();

        // Unused opcode behaves as ADD
        start_req(4'b1111, 16'h1234, 16'h4321, 1'b1);
        check_rsp("op15", 16'h5555, 1'b0, 1'b0);
        check("op15_sel0", sel_log[0], 4'b0000);
        check("op15_sel1", sel_log[1], 4'b0010);
        finish_rsp();

        // Backpressure: held result, second request ignored until handshake
        start_req(4'b0000, 16'h0001, 16'h0002, 1'b0);
        req_valid = 1'b1; req_op = 4'b0000; req_a = 16'h0010; req_b = 16'h0020;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", rsp_valid, 1);
            check("bp_result", rsp_result, 16'h0003);
            check("bp_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_drop", rsp_valid, 0);
        check("bp_idle", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_accepted", req_ready, 0);
        for (int k = 0; k < 3; k++) @(negedge clk);
        check("bp2_early", rsp_valid, 0);
        @(negedge clk);
        check("bp2_valid", rsp_valid, 1);
        check_rsp("bp2", 16'h0030, 1'b0, 1'b0);
        finish_rsp();

`ifdef ALU_SEQ_OVF_EN
        start_req(4'b0000, 16'h7FFF, 16'h0001, 1'b0);
        check_rsp("ovf_add", 16'h8000, 1'b0, 1'b0);
        check("ovf_add_flag", rsp_ovf, 1);
        finish_rsp();

        start_req(4'b0001, 16'h8000, 16'h0001, 1'b0);
        check_rsp("ovf_sub", 16'h7FFF, 1'b0, 1'b0);
        check("ovf_sub_flag", rsp_ovf, 1);
        finish_rsp();

        start_req(4'b0110, 16'h7FFF, 16'hFFFF, 1'b0);
        check("ovf_logic_flag", rsp_ovf, 0);
        finish_rsp();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
